fetch_queue: RTL and testbench

- Decoupled instruction-fetch front end between the instruction port of the unified main memory and the decode stage.
- Generates sequential word-aligned fetch addresses into a memory with a fixed 1-cycle synchronous read latency, and buffers returned {pc, instruction} pairs in a small FIFO.
- Presents the pairs to decode over a valid/ready handshake.
- A redirect input (taken branch/JAL/JALR) flushes the FIFO, squashes in-flight reads, and restarts fetch at the target.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_queue_fifo.sv | 71 +++++++
 rtl/fetch_queue.sv | 119 +++++++++++
 tb/tb_fetch_queue.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction-fetch front end and its decode-side consumers.
package fetch_queue_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int PC_STEP     = 4;

    // Width of one {pc, instruction} entry as seen by decode.
    function automatic int entry_width(input int address_bits);
        return address_bits + INSTR_WIDTH;
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular buffer holding fetched {pc, instruction} entries; head data reads as zero when empty.
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int WIDTH = 16 + INSTR_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never observed while count is zero, so it carries no reset.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count   = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: sequential fetch, credit-limited issue, redirect flush.
// Optional FETCH_QUEUE_STATS_EN adds saturating flush and starvation counters.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                      ADDRESS_BITS = 16,
    parameter int                      DEPTH        = 4,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    mem_req,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    input  logic [31:0]             mem_rdata,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_BITS-1:0] redirect_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDRESS_BITS-1:0] out_pc,
    output logic [31:0]             out_instr,
    output logic [$clog2(DEPTH):0]  count
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [15:0]             stat_flushes,
    output logic [15:0]             stat_starve
`endif
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int SUM_W   = CNT_W + 1;
    localparam int ENTRY_W = entry_width(ADDRESS_BITS);

    logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_BITS-1:0] inflight_pc_q, inflight_pc_d;
    logic                    inflight_q, inflight_d;
    logic [ADDRESS_BITS-1:0] redirect_target;
    logic [SUM_W-1:0]        credits_used;
    logic                    issue, push, pop;
    logic [ENTRY_W-1:0]      head;

    // Entries already buffered plus the read still in flight must leave room for the response.
    assign credits_used    = SUM_W'(count) + SUM_W'(inflight_q);
    assign redirect_target = redirect_pc & ~ADDRESS_BITS'(3);

    always_comb begin
        issue         = !reset && !redirect_valid && (credits_used < SUM_W'(DEPTH));
        push          = inflight_q && !redirect_valid;
        pop           = out_valid && out_ready && !redirect_valid;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDRESS_BITS'(PC_STEP);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clock) begin
        inflight_pc_q <= inflight_pc_d;
    end

    fetch_queue_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear   (redirect_valid),
        .wr_en   (push),
        .wr_data ({inflight_pc_q, mem_rdata}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count)
    );

    assign mem_req              = issue;
    assign mem_addr             = fetch_pc_q;
    assign out_valid            = (count != '0);
    assign {out_pc, out_instr}  = head;

`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0] stat_flushes_q, stat_flushes_d;
    logic [15:0] stat_starve_q, stat_starve_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    always_comb begin
        stat_flushes_d = redirect_valid ? sat_inc(stat_flushes_q) : stat_flushes_q;
        stat_starve_d  = (!out_valid && out_ready) ? sat_inc(stat_starve_q) : stat_starve_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_flushes_q <= '0;
            stat_starve_q  <= '0;
        end else begin
            stat_flushes_q <= stat_flushes_d;
            stat_starve_q  <= stat_starve_d;
        end
    end

    assign stat_flushes = stat_flushes_q;
    assign stat_starve  = stat_starve_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_queue;

    localparam int AB    = 16;
    localparam int DEPTH = 4;
    localparam logic [AB-1:0] RESET_PC = '0;

    logic          clock = 1'b0;
    logic          reset;
    logic          mem_req;
    logic [AB-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic          redirect_valid;
    logic [AB-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [AB-1:0] out_pc;
    logic [31:0]   out_instr;
    logic [2:0]    count;
`ifdef FETCH_QUEUE_STATS_EN
    logic [15:0]   stat_flushes;
    logic [15:0]   stat_starve;
`endif

    always #5 clock = ~clock;

    fetch_queue dut (
        .clock          (clock),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .count          (count)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stat_flushes   (stat_flushes),
        .stat_starve    (stat_starve)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [AB-1:0] pc;
        logic [31:0]   instr;
    } ent_t;

    ent_t          mq[$];
    logic [AB-1:0] m_pc;
    logic [AB-1:0] m_infl_pc;
    bit            m_infl;
    int            m_flush;
    int            m_starve;

    logic          e_req;
    logic [AB-1:0] e_addr;
    logic          e_valid;
    logic [AB-1:0] e_pc;
    logic [31:0]   e_instr;
    int            e_count;

    function automatic logic [31:0] mem_word(input logic [AB-1:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    function automatic void predict();
        e_count = mq.size();
        e_valid = (mq.size() != 0);
        e_pc    = e_valid ? mq[0].pc : '0;
        e_instr = e_valid ? mq[0].instr : '0;
        e_req   = !reset && !redirect_valid && ((mq.size() + int'(m_infl)) < DEPTH);
        e_addr  = m_pc;
    endfunction

    task automatic model_update();
        bit   can_issue;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_pc     = RESET_PC;
            m_infl   = 1'b0;
            m_flush  = 0;
            m_starve = 0;
        end else begin
            if (redirect_valid && m_flush < 65535) m_flush++;
            if (mq.size() == 0 && out_ready && m_starve < 65535) m_starve++;
            if (redirect_valid) begin
                mq.delete();
                m_infl = 1'b0;
                m_pc   = redirect_pc & 16'hFFFC;
            end else begin
                can_issue = (mq.size() + int'(m_infl)) < DEPTH;
                if (mq.size() != 0 && out_ready) void'(mq.pop_front());
                if (m_infl) begin
                    e.pc    = m_infl_pc;
                    e.instr = mem_word(m_infl_pc);
                    mq.push_back(e);
                end
                m_infl    = can_issue;
                m_infl_pc = m_pc;
                if (can_issue) m_pc = m_pc + 16'd4;
            end
        end
    endtask

    task automatic drive(input logic rst, input logic rv, input logic [AB-1:0] rpc, input logic rdy);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #2;
        predict();
    endtask

    // Advance one clock; the memory answers the address seen before the edge.
    task automatic tick();
        logic          req_s;
        logic [AB-1:0] addr_s;
        req_s  = mem_req;
        addr_s = mem_addr;
        model_update();
        @(posedge clock);
        #1;
        mem_rdata = req_s ? mem_word(addr_s) : $urandom();
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, '0, 1'b1);
        vectors++;
        if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        tick();
        drive(1'b1, 1'b0, '0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++;
        if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
        vectors++;
        if (out_pc !== 16'h0 || out_instr !== 32'h0) begin
            miscompares++; $display("FAIL reset_out_data got=%h/%h exp=0/0", out_pc, out_instr);
        end
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
            miscompares++; $display("FAIL release_first_req got=%b/%h exp=1/%h", mem_req, mem_addr, RESET_PC);
        end
        vectors++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            miscompares++; $display("FAIL release_empty got=%b/%0d exp=0/0", out_valid, count);
        end
        tick();
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            vectors++;
            if (mem_req !== 1'b1 || mem_addr !== 16'(4 * i)) begin
                miscompares++; $display("FAIL stream_addr cyc=%0d got=%b/%h exp=1/%h", i, mem_req, mem_addr, 16'(4 * i));
            end
            vectors++;
            if (out_valid !== (i >= 2)) begin
                miscompares++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, out_valid, (i >= 2));
            end
            if (i >= 2) begin
                vectors++;
                if (out_pc !== 16'(4 * (i - 2)) || out_instr !== mem_word(16'(4 * (i - 2)))) begin
                    miscompares++; $display("FAIL stream_data cyc=%0d got=%h/%h exp=%h/%h", i, out_pc, out_instr,
                                            16'(4 * (i - 2)), mem_word(16'(4 * (i - 2))));
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0);
            if (mem_req) begin
                vectors++;
                if (mem_addr !== 16'(4 * nreq)) begin
                    miscompares++; $display("FAIL bp_addr n=%0d got=%h exp=%h", nreq, mem_addr, 16'(4 * nreq));
                end
                nreq++;
            end
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (nreq !== 4) begin miscompares++; $display("FAIL bp_req_count got=%0d exp=4", nreq); end
        vectors++;
        if (count !== 3'd4 || mem_req !== 1'b0) begin
            miscompares++; $display("FAIL bp_full got=%0d/%b exp=4/0", count, mem_req);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 16'(4 * i)) begin
                miscompares++; $display("FAIL bp_drain i=%0d got=%b/%h exp=1/%h", i, out_valid, out_pc, 16'(4 * i));
            end
            if (i == 1) begin
                vectors++;
                if (mem_req !== 1'b1 || mem_addr !== 16'h0010) begin
                    miscompares++; $display("FAIL bp_refetch got=%b/%h exp=1/0010", mem_req, mem_addr);
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            tick();
        end
        drive(1'b0, 1'b1, 16'h0103, 1'b1);
        vectors++;
        if (mem_req !== 1'b0) begin miscompares++; $display("FAIL redir_no_req got=%b exp=0", mem_req); end
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0100) begin
            miscompares++; $display("FAIL redir_target got=%b/%h exp=1/0100", mem_req, mem_addr);
        end
        vectors++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            miscompares++; $display("FAIL redir_flush got=%b/%0d exp=0/0", out_valid, count);
        end
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL redir_squash got=%b pc=%h exp=0", out_valid, out_pc);
        end
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0100 || out_instr !== mem_word(16'h0100)) begin
            miscompares++; $display("FAIL redir_first got=%b/%h/%h exp=1/0100/%h", out_valid, out_pc, out_instr,
                                    mem_word(16'h0100));
        end
        tick();
    endtask

    task automatic test_redirect_pop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 16'h0200, 1'b1);
        vectors++;
        if (count !== 3'd3) begin miscompares++; $display("FAIL rpop_pre_count got=%0d exp=3", count); end
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL rpop_cleared got=%0d/%b exp=0/0", count, out_valid);
        end
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rpop_stale got=%b pc=%h exp=0", out_valid, out_pc); end
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0200) begin
            miscompares++; $display("FAIL rpop_first got=%b/%h exp=1/0200", out_valid, out_pc);
        end
        tick();
    endtask

    task automatic test_wrap_and_midreset();
        logic [AB-1:0] exp_a [4];
        exp_a[0] = 16'hFFF8; exp_a[1] = 16'hFFFC; exp_a[2] = 16'h0000; exp_a[3] = 16'h0004;
        do_reset();
        drive(1'b0, 1'b1, 16'hFFF9, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            if (i < 4) begin
                vectors++;
                if (mem_req !== 1'b1 || mem_addr !== exp_a[i]) begin
                    miscompares++; $display("FAIL wrap_addr i=%0d got=%b/%h exp=1/%h", i, mem_req, mem_addr, exp_a[i]);
                end
            end
            if (i >= 2) begin
                vectors++;
                if (out_pc !== exp_a[i - 2]) begin
                    miscompares++; $display("FAIL wrap_out i=%0d got=%h exp=%h", i, out_pc, exp_a[i - 2]);
                end
            end
            tick();
        end
        drive(1'b1, 1'b0, '0, 1'b1);
        vectors++;
        if (mem_req !== 1'b0) begin miscompares++; $display("FAIL midrst_req got=%b exp=0", mem_req); end
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0 || out_pc !== 16'h0 || out_instr !== 32'h0 || count !== 3'd0) begin
            miscompares++; $display("FAIL midrst_clear got=%b/%h/%h/%0d exp=0/0/0/0", out_valid, out_pc, out_instr, count);
        end
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
            miscompares++; $display("FAIL midrst_restart got=%b/%h exp=1/%h", mem_req, mem_addr, RESET_PC);
        end
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_inflight got=%b exp=0", out_valid); end
        tick();
    endtask

`ifdef FETCH_QUEUE_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 16'h0040, 1'b1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (stat_flushes !== 16'd3) begin miscompares++; $display("FAIL stat_flushes got=%0d exp=3", stat_flushes); end
        vectors++;
        if (stat_starve !== 16'd5) begin miscompares++; $display("FAIL stat_starve got=%0d exp=5", stat_starve); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic rst, rv, rdy;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            rv  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            drive(rst, rv, 16'($urandom()), rdy);
            vectors++;
            if (mem_req !== e_req) begin
                miscompares++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, mem_req, e_req);
            end
            if (e_req) begin
                vectors++;
                if (mem_addr !== e_addr) begin
                    miscompares++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, mem_addr, e_addr);
                end
            end
            vectors++;
            if (out_valid !== e_valid || out_pc !== e_pc || out_instr !== e_instr) begin
                miscompares++; $display("FAIL rnd_head cyc=%0d got=%b/%h/%h exp=%b/%h/%h", i, out_valid, out_pc,
                                        out_instr, e_valid, e_pc, e_instr);
            end
            vectors++;
            if (int'(count) !== e_count) begin
                miscompares++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count, e_count);
            end
`ifdef FETCH_QUEUE_STATS_EN
            vectors++;
            if (int'(stat_flushes) !== m_flush || int'(stat_starve) !== m_starve) begin
                miscompares++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", i, stat_flushes,
                                        stat_starve, m_flush, m_starve);
            end
`endif
            tick();
        end
    endtask

    initial begin
        mem_rdata      = '0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        m_pc           = RESET_PC;
        m_infl_pc      = '0;
        m_infl         = 1'b0;
        m_flush        = 0;
        m_starve       = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_pop();
        test_wrap_and_midreset();
`ifdef FETCH_QUEUE_STATS_EN
        test_stats();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
